reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 104 ++++++++++
 tb/tb_reg_file_sb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard for in-order issue with
// out-of-order writeback. R0 is hardwired to zero and never busy.
module reg_file_sb #(
   parameter int p_WORD_LEN      = 16,
   parameter int p_REG_ADDR_LEN  = 3,
   parameter int p_REG_FILE_SIZE = 8,
   parameter int p_BYPASS        = 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [p_REG_ADDR_LEN-1:0] i_src1,
   input  logic [p_REG_ADDR_LEN-1:0] i_src2,
   output logic [p_WORD_LEN-1:0]     o_src1_data,
   output logic [p_WORD_LEN-1:0]     o_src2_data,
   output logic                      o_src1_busy,
   output logic                      o_src2_busy,
   input  logic [p_REG_ADDR_LEN-1:0] i_tgt,
   input  logic [p_WORD_LEN-1:0]     i_tgt_data,
   input  logic                      i_wr_en,
   input  logic [p_REG_ADDR_LEN-1:0] i_rsv_addr,
   input  logic                      i_rsv_en,
   output logic [p_REG_ADDR_LEN:0]   o_busy_cnt
);

   localparam int CW = p_REG_ADDR_LEN + 1;

   logic [p_WORD_LEN-1:0]      regs [p_REG_FILE_SIZE];
   logic [p_REG_FILE_SIZE-1:0] busy_q;
   logic [p_REG_FILE_SIZE-1:0] busy_d;
   logic [CW-1:0]              busy_cnt_q;
   logic [CW-1:0]              cnt_d;
   logic                       wr_ok;
   logic                       rsv_ok;

   logic [p_REG_ADDR_LEN-1:0]  src_addr [2];
   logic [p_WORD_LEN-1:0]      src_data [2];
   logic                       src_busy [2];

   // R0 and out-of-range addresses never take a write or a reservation.
   assign wr_ok  = i_wr_en  && (i_tgt != '0)      && (int'(i_tgt) < p_REG_FILE_SIZE);
   assign rsv_ok = i_rsv_en && (i_rsv_addr != '0) && (int'(i_rsv_addr) < p_REG_FILE_SIZE);

   // The reserve is applied after the write clear so a same-cycle reserve wins.
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < p_REG_FILE_SIZE; i++) begin
         if (wr_ok && (i_tgt == p_REG_ADDR_LEN'(i)))
            busy_d[i] = 1'b0;
         if (rsv_ok && (i_rsv_addr == p_REG_ADDR_LEN'(i)))
            busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int i = 1; i < p_REG_FILE_SIZE; i++)
         cnt_d = cnt_d + CW'(busy_d[i]);
   end

   assign src_addr[0] = i_src1;
   assign src_addr[1] = i_src2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         src_data[p] = '0;
         src_busy[p] = 1'b0;
         for (int i = 1; i < p_REG_FILE_SIZE; i++) begin
            if (src_addr[p] == p_REG_ADDR_LEN'(i)) begin
               src_data[p] = regs[i];
               src_busy[p] = busy_q[i];
            end
         end
         // Forwarded data is the result itself, so only a new reservation keeps it busy.
         if ((p_BYPASS != 0) && wr_ok && (src_addr[p] == i_tgt)) begin
            src_data[p] = i_tgt_data;
            src_busy[p] = rsv_ok && (i_rsv_addr == src_addr[p]);
         end
      end
   end

   assign o_src1_data = src_data[0];
   assign o_src2_data = src_data[1];
   assign o_src1_busy = src_busy[0];
   assign o_src2_busy = src_busy[1];
   assign o_busy_cnt  = busy_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < p_REG_FILE_SIZE; i++)
            regs[i] <= '0;
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         for (int i = 1; i < p_REG_FILE_SIZE; i++) begin
            if (wr_ok && (i_tgt == p_REG_ADDR_LEN'(i)))
               regs[i] <= i_tgt_data;
         end
         busy_q     <= busy_d;
         busy_cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing instance, a non-bypassing
// instance and a bypassing instance with only 6 registers share one stimulus.
`timescale 1ns/1ps
module tb_reg_file_sb;

   logic        i_clk;
   logic        i_rst_n;
   logic [2:0]  i_src1, i_src2, i_tgt, i_rsv_addr;
   logic [15:0] i_tgt_data;
   logic        i_wr_en, i_rsv_en;

   logic [15:0] a_d1, a_d2, b_d1, b_d2, c_d1, c_d2;
   logic        a_b1, a_b2, b_b1, b_b2, c_b1, c_b2;
   logic [3:0]  a_cnt, b_cnt, c_cnt;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];

   reg_file_sb #(.p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(8), .p_BYPASS(1)) dut_a (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_src1(i_src1), .i_src2(i_src2),
      .o_src1_data(a_d1), .o_src2_data(a_d2), .o_src1_busy(a_b1), .o_src2_busy(a_b2),
      .i_tgt(i_tgt), .i_tgt_data(i_tgt_data), .i_wr_en(i_wr_en),
      .i_rsv_addr(i_rsv_addr), .i_rsv_en(i_rsv_en), .o_busy_cnt(a_cnt));

   reg_file_sb #(.p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(8), .p_BYPASS(0)) dut_b (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_src1(i_src1), .i_src2(i_src2),
      .o_src1_data(b_d1), .o_src2_data(b_d2), .o_src1_busy(b_b1), .o_src2_busy(b_b2),
      .i_tgt(i_tgt), .i_tgt_data(i_tgt_data), .i_wr_en(i_wr_en),
      .i_rsv_addr(i_rsv_addr), .i_rsv_en(i_rsv_en), .o_busy_cnt(b_cnt));

   reg_file_sb #(.p_WORD_LEN(16), .p_REG_ADDR_LEN(3), .p_REG_FILE_SIZE(6), .p_BYPASS(1)) dut_c (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_src1(i_src1), .i_src2(i_src2),
      .o_src1_data(c_d1), .o_src2_data(c_d2), .o_src1_busy(c_b1), .o_src2_busy(c_b2),
      .i_tgt(i_tgt), .i_tgt_data(i_tgt_data), .i_wr_en(i_wr_en),
      .i_rsv_addr(i_rsv_addr), .i_rsv_en(i_rsv_en), .o_busy_cnt(c_cnt));

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      i_wr_en    = 1'b0;
      i_rsv_en   = 1'b0;
      i_tgt      = 3'd0;
      i_tgt_data = 16'h0000;
      i_rsv_addr = 3'd0;
   endtask

   task automatic drive_wr(input logic [2:0] tgt, input logic [15:0] data);
      i_wr_en    = 1'b1;
      i_tgt      = tgt;
      i_tgt_data = data;
   endtask

   task automatic drive_rsv(input logic [2:0] addr);
      i_rsv_en   = 1'b1;
      i_rsv_addr = addr;
   endtask

   task automatic read(input logic [2:0] s1, input logic [2:0] s2);
      i_src1 = s1;
      i_src2 = s2;
      #1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_src1  = 3'd0;
      i_src2  = 3'd0;
      idle();
      #12;
      read(3'd3, 3'd5);
      check("rst_cnt", a_cnt, 4'd0);
      check("rst_data", a_d1, 16'h0000);
      check("rst_busy", a_b2, 1'b0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();

      // write R3, read it back next cycle, R0 reads zero
      drive_wr(3'd3, 16'h1234);
      tick();
      idle();
      read(3'd3, 3'd0);
      check("r3_data", a_d1, 16'h1234);
      check("r3_busy", a_b1, 1'b0);
      check("r0_data", a_d2, 16'h0000);
      check("r0_busy", a_b2, 1'b0);

      // same-cycle forwarding versus stored value
      drive_wr(3'd7, 16'hBEEF);
      read(3'd7, 3'd3);
      check("byp_data", a_d1, 16'hBEEF);
      check("byp_busy", a_b1, 1'b0);
      check("nobyp_data", b_d1, 16'h0000);
      check("oor_byp_data", c_d1, 16'h0000);
      tick();
      idle();
      read(3'd7, 3'd3);
      check("nobyp_after", b_d1, 16'hBEEF);

      // reserve R2 then R5, re-reserve R2, then write R2
      drive_rsv(3'd2);
      tick();
      drive_rsv(3'd5);
      tick();
      idle();
      read(3'd2, 3'd5);
      check("rsv_cnt", a_cnt, 4'd2);
      check("rsv_busy2", a_b1, 1'b1);
      check("rsv_busy5", a_b2, 1'b1);
      check("rsv_cnt_c", c_cnt, 4'd2);
      drive_rsv(3'd2);
      tick();
      idle();
      #1;
      check("rerSV_cnt", a_cnt, 4'd2);
      drive_wr(3'd2, 16'h0022);
      tick();
      idle();
      read(3'd2, 3'd5);
      check("wr2_cnt", a_cnt, 4'd1);
      check("wr2_busy", a_b1, 1'b0);
      check("wr2_data", a_d1, 16'h0022);

      // reserve and write R4 together: reserve wins
      drive_wr(3'd4, 16'h4444);
      drive_rsv(3'd4);
      read(3'd4, 3'd5);
      check("r4_fwd_data", a_d1, 16'h4444);
      check("r4_fwd_busy", a_b1, 1'b1);
      tick();
      idle();
      read(3'd4, 3'd5);
      check("r4_data", a_d1, 16'h4444);
      check("r4_busy", a_b1, 1'b1);
      check("r4_cnt", a_cnt, 4'd2);

      // write and reserve R0 are ignored
      drive_wr(3'd0, 16'hFFFF);
      drive_rsv(3'd0);
      read(3'd0, 3'd0);
      check("r0w_data_now", a_d1, 16'h0000);
      check("r0w_busy_now", a_b1, 1'b0);
      tick();
      idle();
      read(3'd0, 3'd4);
      check("r0w_data", a_d1, 16'h0000);
      check("r0w_busy", a_b1, 1'b0);
      check("r0w_cnt", a_cnt, 4'd2);

      // R6 is out of range for the 6-entry instance
      drive_rsv(3'd6);
      tick();
      idle();
      read(3'd6, 3'd7);
      check("oor_rsv_cnt_a", a_cnt, 4'd3);
      check("oor_rsv_cnt_c", c_cnt, 4'd2);
      check("oor_rsv_busy_c", c_b1, 1'b0);
      drive_wr(3'd6, 16'h6666);
      tick();
      idle();
      read(3'd6, 3'd7);
      check("oor_wr_data_a", a_d1, 16'h6666);
      check("oor_wr_data_c", c_d1, 16'h0000);
      check("oor_rd7_c", c_d2, 16'h0000);
      check("oor_wr_cnt_a", a_cnt, 4'd2);

      // three busy plus R1=AAAA, then reset in mid-cycle
      drive_wr(3'd1, 16'hAAAA);
      drive_rsv(3'd3);
      tick();
      idle();
      read(3'd1, 3'd4);
      check("pre_rst_cnt", a_cnt, 4'd3);
      check("pre_rst_r1", a_d1, 16'hAAAA);
      drive_wr(3'd2, 16'h1111);
      drive_rsv(3'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      i_src2 = 3'd3;
      #1;
      check("mid_rst_r1", a_d1, 16'h0000);
      check("mid_rst_busy", a_b2, 1'b0);
      check("mid_rst_cnt", a_cnt, 4'd0);
      check("mid_rst_cnt_b", b_cnt, 4'd0);
      tick();
      idle();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      read(3'd2, 3'd1);
      check("post_rst_cnt", a_cnt, 4'd0);
      check("post_rst_r2", a_d1, 16'h0000);
      check("post_rst_busy1", a_b2, 1'b0);

      // resume and sweep the whole file through the expected queue
      drive_wr(3'd1, 16'h5555);
      tick();
      idle();
      for (int i = 0; i < 8; i++)
         exp_q.push_back((i == 1) ? 16'h5555 : 16'h0000);
      for (int i = 0; i < 8; i++) begin
         read(3'(i), 3'(i));
         check($sformatf("sweep_r%0d", i), a_d1, exp_q.pop_front());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
